imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Arbiter and sequencer for the single-port instruction memory: shares one word-addressed read/write port between the CPU fetch stage and a debug/program-load port. Grants one access per cycle, fetch has priority subject to an aging limit, and a halt protocol drains in-flight fetches before giving the debug port exclusive access. It sits between the fetch unit and `imem`.

## Interface
- `DEPTH`, 64: memory depth in 32-bit words (power of two).
- `MAX_WAIT`, 4: consecutive cycles a debug request may be refused before it wins over fetch.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fetch_req`  in  1  fetch read request.
- `fetch_addr`  in  32  byte address.
- `fetch_gnt`  out  1  request accepted this cycle.
- `fetch_rvalid`  out  1  read data valid.
- `fetch_rdata`  out  32  read data.
- `dbg_req`  in  1  debug request.
- `dbg_we`  in  1  1 = write, 0 = read.
- `dbg_addr`  in  32  byte address.
- `dbg_wdata`  in  32  write data.
- `dbg_halt`  in  1  level; request exclusive access.
- `dbg_halted`  out  1  exclusive access in effect.
- `dbg_gnt`  out  1  request accepted this cycle.
- `dbg_rvalid`  out  1  read data or write acknowledge.
- `dbg_rdata`  out  32  read data (0 for writes).
- `err`  out  1  one-cycle pulse: out-of-range access.
- `mem_en`, `mem_we`  out  1 each  memory strobes.
- `mem_addr`  out  log2(DEPTH)  word index.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data, valid one cycle after `mem_en`.

## Operation
- Word index = `addr[log2(DEPTH)+1:2]`. Bits [1:0] are ignored. An address ≥ 4*DEPTH is out of range.
- FSM states:
  - RUN (reset state).
  - HALT_PEND: entered from RUN when `dbg_halt` = 1.
    - No fetch grants are issued.
    - Moves to HALTED once no fetch response is outstanding.
  - HALTED: `dbg_halted` = 1 and only debug is granted. Returns to RUN when `dbg_halt` = 0.
  - `dbg_halt` = 0 in HALT_PEND returns to RUN.
- RUN arbitration:
  - Only one requester asserted: grant it.
  - Both asserted: fetch wins unless `wait_cnt` = MAX_WAIT, in which case debug wins.
- `wait_cnt` behaviour:
  - Increments each cycle `dbg_req` is asserted and refused, saturating at MAX_WAIT.
  - Clears on a debug grant, or when `dbg_req` = 0.
- Debug is served in every state.
- A grant drives `mem_en` = 1 in the same cycle. `mem_we` = `dbg_we` for debug and 0 for fetch.
- Out-of-range grant:
  - `mem_en` stays 0.
  - The response is delivered next cycle with rdata = 0 and `err` = 1.
  - Writes are dropped.
- Each grant produces exactly one rvalid to the granted port, in issue order.

## Timing
- `gnt` is combinational from req, state and `wait_cnt` in the request cycle.
- `rvalid` and rdata are registered and appear exactly 1 cycle after `gnt`. Full throughput: 1 access/cycle.
- A requester holds req/addr until it sees `gnt`; the address is sampled only in the gnt cycle.
- Debug write: memory is written at the gnt edge, and `dbg_rvalid` follows 1 cycle later with rdata = 0.
- Debug read of an address written in the previous cycle returns the new data.
- RUN→HALT_PEND→HALTED takes a minimum of 2 cycles after `dbg_halt` rises when a fetch was granted in the rise cycle, and 1 cycle otherwise.
- Reset:
  - All outputs are 0; state = RUN; `wait_cnt` = 0.
  - In-flight responses are discarded, so no rvalid follows reset release.

## Configuration
- `IMEM_ARB_WRITE_EN` defined: debug writes are performed as above.
- Undefined:
  - `dbg_we` is ignored and every debug access is a read.
  - `mem_we` is tied to 0 and `mem_wdata` to 0.

## Structure
- Package `imem_pkg` holds:
  - the state enum (RUN, HALT_PEND, HALTED);
  - the port-select encoding (SEL_NONE, SEL_FETCH, SEL_DBG);
  - the default DEPTH and MAX_WAIT.
- One sub-module is natural: `imem_arb_resp`, the 1-cycle response register.
  - Captures the port select, error and write flag.
  - Steers `mem_rdata` to the correct port.

## Test plan
- Fetch only, addresses 0,4,…,252 back-to-back → one `fetch_gnt` per cycle; `fetch_rvalid` 1 cycle later with the preloaded words; `err` never asserted.
- Both requesting continuously, MAX_WAIT=4 → grant pattern fetch×4, dbg, fetch×4, dbg; `wait_cnt` returns to 0 after each debug grant.
- `dbg_halt` raised in the same cycle as a fetch grant → HALT_PEND for 1 cycle, then `dbg_halted`; the in-flight fetch rvalid arrives and no further `fetch_gnt` is issued while halted.
- Halted, debug write 32'hDEADBEEF @ 0x10, then read @ 0x10 → read returns 32'hDEADBEEF. With `IMEM_ARB_WRITE_EN` undefined, the read returns the original word.
- Debug read @ 0x100 (DEPTH=64) → `mem_en`=0, `dbg_rvalid`=1 with rdata 0, `err`=1 for one cycle.
- Reset asserted the cycle after a fetch grant → no `fetch_rvalid` after release; all outputs 0; the next fetch is granted normally.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
package imem_pkg;

  localparam int unsigned DEF_DEPTH    = 64;
  localparam int unsigned DEF_MAX_WAIT = 4;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_FETCH = 2'd1,
    SEL_DBG   = 2'd2
  } port_sel_e;

  // word_addr is the byte address with bits [1:0] already dropped
  function automatic logic addr_in_range(input logic [29:0] word_addr,
                                         input int unsigned depth);
    logic [31:0] word;
    word = {2'b00, word_addr};
    return word < depth;
  endfunction

endpackage

// File: rtl/imem_arb_resp.sv
// One-cycle response register: remembers who was granted and steers the
// memory read data (valid one cycle after mem_en) back to that port.
module imem_arb_resp
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  port_sel_e   issue_sel,
  input  logic        issue_err,
  input  logic        issue_wr,
  input  logic [31:0] mem_rdata,
  output logic        fetch_rvalid,
  output logic [31:0] fetch_rdata,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        err
);

  port_sel_e sel_q;
  logic      err_q;
  logic      wr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= SEL_NONE;
      err_q <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      sel_q <= issue_sel;
      err_q <= issue_err && (issue_sel != SEL_NONE);
      wr_q  <= issue_wr;
    end
  end

  // Errored accesses and write acknowledges return zero data.
  always_comb begin
    fetch_rvalid = (sel_q == SEL_FETCH);
    dbg_rvalid   = (sel_q == SEL_DBG);
    err          = err_q;
    fetch_rdata  = '0;
    dbg_rdata    = '0;
    if (fetch_rvalid && !err_q)
      fetch_rdata = mem_rdata;
    if (dbg_rvalid && !err_q && !wr_q)
      dbg_rdata = mem_rdata;
  end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter: fetch priority with debug aging and a halt
// handshake. Define IMEM_ARB_WRITE_EN to allow debug writes.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [31:0]              fetch_addr,
  output logic                     fetch_gnt,
  output logic                     fetch_rvalid,
  output logic [31:0]              fetch_rdata,
  input  logic                     dbg_req,
  input  logic                     dbg_we,
  input  logic [31:0]              dbg_addr,
  input  logic [31:0]              dbg_wdata,
  input  logic                     dbg_halt,
  output logic                     dbg_halted,
  output logic                     dbg_gnt,
  output logic                     dbg_rvalid,
  output logic [31:0]              dbg_rdata,
  output logic                     err,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  arb_state_e     state_q, state_d;
  logic [WW-1:0]  wait_cnt_q;
  logic           wait_max;
  logic           dbg_we_eff;
  logic [31:0]    dbg_wdata_eff;
  logic           fetch_ok, dbg_ok;
  logic           issue_err;
  port_sel_e      issue_sel;
  logic           unused_bits;

`ifdef IMEM_ARB_WRITE_EN
  assign dbg_we_eff    = dbg_we;
  assign dbg_wdata_eff = dbg_wdata;
  assign unused_bits   = ^{fetch_addr[1:0], dbg_addr[1:0]};
`else
  assign dbg_we_eff    = 1'b0;
  assign dbg_wdata_eff = '0;
  assign unused_bits   = ^{fetch_addr[1:0], dbg_addr[1:0], dbg_we, dbg_wdata};
`endif

  assign wait_max   = (wait_cnt_q == WW'(MAX_WAIT));
  assign fetch_ok   = addr_in_range(fetch_addr[31:2], DEPTH);
  assign dbg_ok     = addr_in_range(dbg_addr[31:2], DEPTH);
  assign dbg_halted = (state_q == HALTED);

  // Grants are held low during reset so every output reads zero.
  always_comb begin
    fetch_gnt = 1'b0;
    dbg_gnt   = 1'b0;
    if (!rst) begin
      if (state_q == RUN) begin
        dbg_gnt   = dbg_req && (!fetch_req || wait_max);
        fetch_gnt = fetch_req && !dbg_gnt;
      end else begin
        dbg_gnt = dbg_req;
      end
    end
  end

  // With a one-cycle response, a fetch granted in the halt-rise cycle is
  // answered during HALT_PEND; without one, HALTED is reached directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:       if (dbg_halt) state_d = fetch_gnt ? HALT_PEND : HALTED;
      HALT_PEND: state_d = dbg_halt ? HALTED : RUN;
      HALTED:    if (!dbg_halt) state_d = RUN;
      default:   state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (!dbg_req || dbg_gnt)
        wait_cnt_q <= '0;
      else if (!wait_max)
        wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    issue_err = 1'b0;
    issue_sel = SEL_NONE;
    if (dbg_gnt) begin
      issue_sel = SEL_DBG;
      issue_err = !dbg_ok;
      if (dbg_ok) begin
        mem_en   = 1'b1;
        mem_we   = dbg_we_eff;
        mem_addr = dbg_addr[AW+1:2];
        if (dbg_we_eff)
          mem_wdata = dbg_wdata_eff;
      end
    end else if (fetch_gnt) begin
      issue_sel = SEL_FETCH;
      issue_err = !fetch_ok;
      if (fetch_ok) begin
        mem_en   = 1'b1;
        mem_addr = fetch_addr[AW+1:2];
      end
    end
  end

  imem_arb_resp u_resp (
    .clk          (clk),
    .rst          (rst),
    .issue_sel    (issue_sel),
    .issue_err    (issue_err),
    .issue_wr     (dbg_gnt && dbg_we_eff),
    .mem_rdata    (mem_rdata),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .dbg_rvalid   (dbg_rvalid),
    .dbg_rdata    (dbg_rdata),
    .err          (err)
  );

endmodule

// File: tb/tb_imem_arbiter.sv
// Table-driven bench for imem_arbiter with a response scoreboard and a
// behavioural single-port memory.
module tb_imem_arbiter;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;
`ifdef IMEM_ARB_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req, fetch_gnt, fetch_rvalid;
  logic [31:0]   fetch_addr, fetch_rdata;
  logic          dbg_req, dbg_we, dbg_halt, dbg_halted, dbg_gnt, dbg_rvalid;
  logic [31:0]   dbg_addr, dbg_wdata, dbg_rdata;
  logic          err, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  imem_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_halt(dbg_halt), .dbg_halted(dbg_halted), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic        f;
    logic [31:0] fa;
    logic        d;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        h;
    logic        ef;
    logic        ed;
    logic        eh;
  } vec_t;

  typedef struct {
    logic        is_dbg;
    logic [31:0] data;
    logic        err;
  } resp_t;

  vec_t  tbl[$];
  resp_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic vec_t mk(logic f, logic [31:0] fa, logic d, logic dwe,
                              logic [31:0] da, logic [31:0] dwd, logic h,
                              logic ef, logic ed, logic eh);
    vec_t v;
    v.f = f; v.fa = fa; v.d = d; v.dwe = dwe; v.da = da; v.dwd = dwd; v.h = h;
    v.ef = ef; v.ed = ed; v.eh = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_resp(input string tag);
    resp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, " fetch_rvalid"}, {31'b0, fetch_rvalid}, {31'b0, !e.is_dbg});
      chk({tag, " dbg_rvalid"}, {31'b0, dbg_rvalid}, {31'b0, e.is_dbg});
      chk({tag, " rdata"}, e.is_dbg ? dbg_rdata : fetch_rdata, e.data);
      chk({tag, " err"}, {31'b0, err}, {31'b0, e.err});
    end else begin
      chk({tag, " idle_resp"}, {29'b0, fetch_rvalid, dbg_rvalid, err}, 32'd0);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string       tag;
    logic        f_in, d_in, we_eff, exp_en;
    logic [31:0] exp_idx;
    resp_t       r;
    tag = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    fetch_req = v.f; fetch_addr = v.fa;
    dbg_req = v.d; dbg_we = v.dwe; dbg_addr = v.da; dbg_wdata = v.dwd;
    dbg_halt = v.h;
    #4;
    check_resp(tag);
    f_in   = (v.fa < 32'(4 * DEPTH));
    d_in   = (v.da < 32'(4 * DEPTH));
    we_eff = v.dwe && WR_EN;
    exp_en = (v.ed && d_in) || (v.ef && f_in);
    exp_idx = v.ed ? (v.da >> 2) : (v.fa >> 2);
    chk({tag, " fetch_gnt"}, {31'b0, fetch_gnt}, {31'b0, v.ef});
    chk({tag, " dbg_gnt"}, {31'b0, dbg_gnt}, {31'b0, v.ed});
    chk({tag, " dbg_halted"}, {31'b0, dbg_halted}, {31'b0, v.eh});
    chk({tag, " mem_en"}, {31'b0, mem_en}, {31'b0, exp_en});
    chk({tag, " mem_we"}, {31'b0, mem_we}, {31'b0, exp_en && v.ed && we_eff});
    if (exp_en) chk({tag, " mem_addr"}, {26'b0, mem_addr}, exp_idx);
    if (exp_en && v.ed && we_eff) chk({tag, " mem_wdata"}, mem_wdata, v.dwd);
    if (v.ed) begin
      r.is_dbg = 1'b1;
      r.err    = !d_in;
      r.data   = (!d_in || we_eff) ? 32'd0 : ref_mem[v.da[AW+1:2]];
      exp_q.push_back(r);
      if (d_in && we_eff) ref_mem[v.da[AW+1:2]] = v.dwd;
    end else if (v.ef) begin
      r.is_dbg = 1'b0;
      r.err    = !f_in;
      r.data   = f_in ? ref_mem[v.fa[AW+1:2]] : 32'd0;
      exp_q.push_back(r);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " ctrl"}, {24'b0, fetch_gnt, fetch_rvalid, dbg_halted, dbg_gnt,
                         dbg_rvalid, err, mem_en, mem_we}, 32'd0);
    chk({tag, " fetch_rdata"}, fetch_rdata, 32'd0);
    chk({tag, " dbg_rdata"}, dbg_rdata, 32'd0);
    chk({tag, " mem_addr"}, {26'b0, mem_addr}, 32'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]     = 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0203);
      ref_mem[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0203);
    end
    mem_rdata = '0;
    rst = 1'b1;
    fetch_req = 1'b1; fetch_addr = 32'h4; dbg_req = 1'b1; dbg_we = 1'b1;
    dbg_addr = 32'h8; dbg_wdata = 32'h1234_5678; dbg_halt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");

    // fetch sweep over the whole memory, back to back
    for (int i = 0; i < int'(DEPTH); i++)
      tbl.push_back(mk(1, 32'(4 * i), 0, 0, 0, 0, 0, 1, 0, 0));
    // both requesting: fetch x4, dbg, fetch x4, dbg
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(1, 32'(4 * k), 1, 0, 32'h20, 0, 0, (k % 5) != 4, (k % 5) == 4, 0));
    // dropping dbg_req clears the aging count
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1, 32'h30, 1, 0, 32'h24, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 32'h34, 0, 0, 32'h24, 0, 0, 1, 0, 0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1, 32'h38, 1, 0, 32'h24, 0, 0, k != 4, k == 4, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h28, 0, 0, 0, 1, 0));
    // halt raised with a fetch grant, debug access while halted
    tbl.push_back(mk(1, 32'h40, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 32'h40, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 32'h40, 0, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 32'h40, 1, 1, 32'h10, 32'hDEAD_BEEF, 1, 0, 1, 1));
    tbl.push_back(mk(1, 32'h40, 1, 0, 32'h10, 0, 1, 0, 1, 1));
    tbl.push_back(mk(1, 32'h40, 1, 0, 32'h100, 0, 1, 0, 1, 1));
    tbl.push_back(mk(1, 32'h40, 0, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0));
    // halt raised with no fetch: straight to halted
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 32'h44, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 32'h44, 0, 0, 0, 0, 0, 1, 0, 0));
    // halt abandoned during HALT_PEND; debug still served there
    tbl.push_back(mk(1, 32'h48, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 32'h4C, 1, 0, 32'h0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 32'h4C, 0, 0, 0, 0, 0, 1, 0, 0));
    // out-of-range fetches and the last valid word
    tbl.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 32'hFF, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 32'h1000_0000, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    fetch_req = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_halt = 1'b0;
    rst = 1'b0;
    foreach (tbl[i]) run_vec(tbl[i], i);

    // reset in the cycle after a fetch grant discards its response
    run_vec(mk(1, 32'h8, 0, 0, 0, 0, 0, 1, 0, 0), 1000);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    #4;
    check_all_zero("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0; fetch_req = 1'b0;
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1001);
    run_vec(mk(1, 32'hC, 0, 0, 0, 0, 0, 1, 0, 0), 1002);
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1003);
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
